// File: rtl/scan_out_ctrl.sv
// Raster scan-out controller: timing generation, ping-pong buffer reads and a 2-stage aligned pixel output.
// Optional build macro TEST_PATTERN_EN adds pat_en, which selects a position-derived test pattern instead of buffer data.
module scan_out_ctrl #(
  parameter int H_ACTIVE = 100,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 8,
  parameter int V_ACTIVE = 100,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
`ifdef TEST_PATTERN_EN
  input  logic              pat_en,
`endif
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              disp_buf,
  output logic              RE0,
  output logic              RE1,
  output logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] R0,
  input  logic [DATA_W-1:0] G0,
  input  logic [DATA_W-1:0] B0,
  input  logic [DATA_W-1:0] R1,
  input  logic [DATA_W-1:0] G1,
  input  logic [DATA_W-1:0] B1,
  output logic [DATA_W-1:0] pix_r,
  output logic [DATA_W-1:0] pix_g,
  output logic [DATA_W-1:0] pix_b,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int VS_BEG  = V_ACTIVE + V_FP;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          pend;
  logic          active, h_wrap, f_wrap, hs_raw, vs_raw, rd_en;

  assign active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign h_wrap = (int'(h_cnt) == H_TOTAL - 1);
  assign f_wrap = h_wrap && (int'(v_cnt) == V_TOTAL - 1);
  assign hs_raw = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_BEG + H_SYNC);
  assign vs_raw = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_BEG + V_SYNC);

  // Strobes are gated by the reset pin itself so they drop immediately on an async reset.
`ifdef TEST_PATTERN_EN
  assign rd_en = reset & en & active & ~pat_en;
`else
  assign rd_en = reset & en & active;
`endif
  assign RE0 = rd_en & ~disp_buf;
  assign RE1 = rd_en & disp_buf;

  // Raster position, incremental read address and buffer swap control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      Addr     <= '0;
      disp_buf <= 1'b0;
      pend     <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (swap_req) pend <= 1'b1;
      if (en) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= f_wrap ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
        if (f_wrap)      Addr <= '0;
        else if (active) Addr <= Addr + ADDR_W'(1);
        // Pending is cleared at the wrap it is honoured on; a request seen on that same cycle waits a frame.
        if (f_wrap && pend) begin
          disp_buf <= ~disp_buf;
          swap_ack <= 1'b1;
          pend     <= 1'b0;
        end
      end
    end
  end

  // Stage 1: buffer registers its data; timing and select travel alongside
  logic vld_p1, hs_p1, vs_p1, fs_p1, sel_p1, pat_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      fs_p1  <= 1'b0;
      sel_p1 <= 1'b0;
      pat_p1 <= 1'b0;
    end else begin
      vld_p1 <= en & active;
      hs_p1  <= en & hs_raw;
      vs_p1  <= en & vs_raw;
      fs_p1  <= en & active & (h_cnt == '0) & (v_cnt == '0);
      sel_p1 <= disp_buf;
`ifdef TEST_PATTERN_EN
      pat_p1 <= pat_en;
`else
      pat_p1 <= 1'b0;
`endif
    end
  end

  logic [DATA_W-1:0] tr_p1, tg_p1, tb_p1;

`ifdef TEST_PATTERN_EN
  always_ff @(posedge clk) begin
    tr_p1 <= DATA_W'(h_cnt);
    tg_p1 <= DATA_W'(v_cnt);
    tb_p1 <= ~DATA_W'(h_cnt);
  end
`else
  assign tr_p1 = '0;
  assign tg_p1 = '0;
  assign tb_p1 = '0;
`endif

  // Stage 2: registered output pixel and timing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
    end else begin
      de          <= vld_p1;
      hsync       <= hs_p1;
      vsync       <= vs_p1;
      frame_start <= fs_p1;
      if (!vld_p1) begin
        pix_r <= '0;
        pix_g <= '0;
        pix_b <= '0;
      end else if (pat_p1) begin
        pix_r <= tr_p1;
        pix_g <= tg_p1;
        pix_b <= tb_p1;
      end else if (sel_p1) begin
        pix_r <= R1;
        pix_g <= G1;
        pix_b <= B1;
      end else begin
        pix_r <= R0;
        pix_g <= G0;
        pix_b <= B0;
      end
    end
  end

endmodule

// File: tb/tb_scan_out_ctrl.sv
// Scoreboard bench for scan_out_ctrl: a raster model predicts strobes/address per cycle and queues pixel outputs 2 cycles ahead.
module tb_scan_out_ctrl;
  localparam int HA    = 100;
  localparam int VA    = 100;
  localparam int HT    = 120;
  localparam int VT    = 106;
  localparam int AW    = 20;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;
  logic swap_req = 1'b0;
  logic swap_ack, disp_buf, RE0, RE1, de, hsync, vsync, frame_start;
  logic [AW-1:0] Addr;
  logic [7:0] R0 = '0, G0 = '0, B0 = '0, R1 = '0, G1 = '0, B1 = '0;
  logic [7:0] pix_r, pix_g, pix_b;
`ifdef TEST_PATTERN_EN
  logic pat_en = 1'b0;
`endif

  always #5 clk = ~clk;

  scan_out_ctrl dut (
    .clk(clk), .reset(reset), .en(en),
`ifdef TEST_PATTERN_EN
    .pat_en(pat_en),
`endif
    .swap_req(swap_req), .swap_ack(swap_ack), .disp_buf(disp_buf),
    .RE0(RE0), .RE1(RE1), .Addr(Addr),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  // Frame buffers: Buf0 word = address, Buf1 word = ~address, registered on read
  always @(posedge clk) begin
    if (RE0) {B0, G0, R0} <= 24'(Addr);
    if (RE1) {B1, G1, R1} <= ~24'(Addr);
  end

  int n_chk = 0, n_err = 0;
  int mh, mv, cyc, de_cnt, fs_seen, last_fs, ack_cnt;
  logic mbuf, mpend, mack, auto_drop;
  logic [27:0] sb[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, h=%0d v=%0d)", tag, act, exp, cyc, mh, mv);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int h, input int v);
    if (v >= VA) return AW'(HA * VA);
    if (h >= HA) return AW'((v + 1) * HA);
    return AW'(v * HA + h);
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mbuf = 1'b0; mpend = 1'b0; mack = 1'b0;
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
    de_cnt = 0; fs_seen = 0;
  endtask

  // One clock cycle: entered in the low phase with inputs set, leaves at the next negedge
  task automatic step();
    logic act, old_pend, e_de;
    logic [AW-1:0] ea;
    logic [23:0] word;
    logic [27:0] e;
    #1;
    act  = (mh < HA) && (mv < VA);
    e_de = en && act;
    ea   = exp_addr(mh, mv);
    check("rd", 64'({RE0, RE1, disp_buf, swap_ack, Addr}),
          64'({e_de && !mbuf, e_de && mbuf, mbuf, mack, ea}));
    word = mbuf ? ~24'(ea) : 24'(ea);
    e = {e_de, en && (mh >= HA + 4) && (mh < HA + 12), en && (mv >= VA + 2) && (mv < VA + 4),
         e_de && (mh == 0) && (mv == 0), e_de ? word : 24'h0};
    sb.push_back(e);
    check("out", 64'({de, hsync, vsync, frame_start, pix_b, pix_g, pix_r}), 64'(sb.pop_front()));
    if (frame_start) begin
      if (fs_seen > 0) check("de_count", 64'(de_cnt), 64'(HA * VA));
      if (fs_seen == 1) check("period", 64'(cyc - last_fs), 64'(FRAME));
      last_fs = cyc; fs_seen++; de_cnt = 0;
    end
    if (de) de_cnt++;
    if (swap_ack) ack_cnt++;
    if (e_de && mh == HA - 1 && (mv == 0 || mv == VA - 1))
      check("addr_eol", 64'(Addr), 64'(mv * HA + HA - 1));
    old_pend = mpend;
    mack = 1'b0;
    if (swap_req) mpend = 1'b1;
    if (en) begin
      if (mh == HT - 1 && mv == VT - 1 && old_pend) begin
        mbuf = ~mbuf; mack = 1'b1; mpend = 1'b0;
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    cyc++;
    @(negedge clk);
    if (auto_drop && swap_ack) swap_req = 1'b0;
  endtask

  task automatic run_to(input int h, input int v, input int limit);
    int n = 0;
    while (!(mh == h && mv == v) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) check("run_to", 64'(n), 64'(0));
  endtask

  initial begin
    cyc = 0; ack_cnt = 0; last_fs = 0; auto_drop = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_state", 64'({RE0, RE1, swap_ack, disp_buf, de, hsync, vsync, frame_start,
                            pix_r, pix_g, pix_b, Addr}), 64'(0));
    reset = 1'b1;
    model_reset();
    step();
    run_to(0, 0, FRAME + 50);
    // Swap requested mid-frame 1, held until acknowledged
    run_to(20, 50, FRAME + 50);
    swap_req = 1'b1;
    auto_drop = 1'b1;
    run_to(10, 0, FRAME + 50);
    check("ack_cnt", 64'(ack_cnt), 64'(1));
    check("disp_buf", 64'(disp_buf), 64'(1));
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    run_to(50, 40, 2 * FRAME);
    // Async reset between clock edges
    reset = 1'b0;
    #1;
    check("rst_async", 64'({RE0, RE1, swap_ack, disp_buf, de, hsync, vsync, frame_start,
                            pix_r, pix_g, pix_b, Addr}), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (300) step();
    check("ack_final", 64'(ack_cnt), 64'(1));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/scan_out_ctrl.md
Name: scan_out_ctrl

Overview:
- Display scan-out stage directly downstream of the frame buffers (Buf0 and its twin Buf1).
- Generates raster timing (hsync, vsync, de) and issues read strobes and addresses to the displayed buffer.
- Consumes the buffer's registered R/G/B outputs and presents an aligned pixel stream to the display interface.
- Owns ping-pong buffer selection; buffer swaps happen only at frame boundaries.

Parameters:
H_ACTIVE, 100, active pixels per line
H_FP, 4, horizontal front porch (cycles)
H_SYNC, 8, hsync width (cycles)
H_BP, 8, horizontal back porch (cycles)
V_ACTIVE, 100, active lines per frame
V_FP, 2, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 2, vertical back porch (lines)
ADDR_W, 20, buffer address width

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
en  in  1  scan enable
swap_req  in  1  request to swap the displayed buffer; level, held until swap_ack
swap_ack  out  1  one-cycle pulse when a swap takes effect
disp_buf  out  1  currently displayed buffer (0 = Buf0, 1 = Buf1)
RE0  out  1  read enable to Buf0
RE1  out  1  read enable to Buf1
Addr  out  ADDR_W  read address shared by both buffers
R0, G0, B0  in  8 each  Buf0 read data, valid 1 cycle after RE0
R1, G1, B1  in  8 each  Buf1 read data, valid 1 cycle after RE1
pix_r, pix_g, pix_b  out  8 each  output pixel
de  out  1  output pixel valid
hsync  out  1  active-high horizontal sync
vsync  out  1  active-high vertical sync
frame_start  out  1  one-cycle pulse coincident with de of pixel (0,0)

Behaviour:
- Reset (reset = 0, asynchronous): all counters 0, Addr = 0, disp_buf = 0, every output 0. Applies mid-frame without exception; after release the scan restarts at (h,v) = (0,0).
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (120 at defaults).
  - v_cnt runs 0..V_TOTAL-1 (106 at defaults) and increments when h_cnt wraps.
  - Both wrap to 0 together at (H_TOTAL-1, V_TOTAL-1).
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Addr:
  - Incremental counter, not a multiplier. Increments after each active cycle and holds during blanking.
  - Cleared to 0 at frame wrap, so Addr = v*H_ACTIVE + h during active cycles; the last pixel reads 9999 at defaults.
- Read strobe: in active cycles, the RE of buffer disp_buf is 1; the other RE is always 0, leaving that buffer free for writes. Both REs are 0 outside active.
- Pipeline (total latency 2 cycles from counter position to outputs):
  - Stage 1: the buffer registers its data.
  - Stage 2: this block registers pix_*, de, hsync, vsync, frame_start.
  - pix_* = data from the selected buffer when de = 1, else 0.
- Sync timing: hsync = 1 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses the same rule on v_cnt. Both are delayed 2 cycles like de.
- Swap:
  - swap_req is sampled into a pending flag.
  - At the frame-wrap cycle, if pending: toggle disp_buf, pulse swap_ack in the following cycle, clear pending.
  - swap_req held continuously yields exactly one swap per frame.
  - A request arriving on the wrap cycle itself takes effect at the next wrap.
  - Stage-2 select uses a copy of disp_buf delayed by 1 cycle, so in-flight pixels come from the buffer that was read.
- en = 0:
  - Counters, Addr and disp_buf hold; RE0 = RE1 = 0.
  - de, hsync, vsync, frame_start and pix_* are driven 0 from 2 cycles later.
  - When en returns to 1, the scan resumes from the held position.

Optional Feature:
TEST_PATTERN_EN
- Defined: adds input port pat_en (1 bit). When pat_en = 1, RE0 = RE1 = 0, and the output pixel at position (h,v) is R = h[7:0], G = v[7:0], B = 8'hFF ^ h[7:0], with the same 2-cycle alignment to de. Timing and swap behaviour are unchanged. pat_en is sampled per cycle, so a mid-frame change switches source at the pixel boundary.
- Undefined: no pat_en port; pixels always come from the buffers.

Test Plan:
- Reset release with en = 1 -> RE0 = 1, Addr = 0 in cycle 0; de = 1 and frame_start = 1 at cycle 2; RE1 never asserted; Addr = 99 at h = 99, v = 0.
- Full frame at defaults -> exactly 10000 de cycles; last Addr = 9999; hsync high 8 cycles starting at h = 104 (output delayed 2); vsync high for lines 102-103; frame period 12720 cycles.
- Buffer model with Buf0 word = address and Buf1 word = ~address -> pix_{b,g,r} = {Addr[23:16], Addr[15:8], Addr[7:0]} of the read 2 cycles earlier; zero pixels whenever de = 0.
- swap_req raised mid-frame -> disp_buf stays 0 until wrap; swap_ack pulses once after wrap; the next frame reads via RE1 only; the last pixels of the old frame still come from Buf0.
- Async reset asserted at (h = 50, v = 40) -> all outputs 0 immediately, without waiting for a clock edge; after release, scan restarts with Addr = 0 and disp_buf = 0.
- en low at (h = 10, v = 0) for 5 cycles -> outputs blank after 2 cycles; on resume Addr continues at 10; the frame still totals 10000 de cycles.
